// File: rtl/bpb_pkg.sv
// ---------------------------------------------------------------------------
// bpb_pkg
//   Shared types and constants for the branch prediction buffer update path.
//   - TAG_W / BPB_ENTRIES : tag width and line count of the BPB line array.
//   - INDEX_W             : line index width.
//   - DROP_CNT_MAX        : saturation value of the drop counter.
//   - upd_kind_e          : counter update (UPD_SW) or line allocation (UPD_ALLOC).
//   - upd_entry_t         : one queued update.
//   - sat_inc8()          : saturating 8-bit increment.
// ---------------------------------------------------------------------------
package bpb_pkg;

    localparam int TAG_W = 20;

    localparam int BPB_ENTRIES = 32;

    localparam int INDEX_W = $clog2(BPB_ENTRIES);

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    typedef enum logic {
        UPD_SW    = 1'b0,
        UPD_ALLOC = 1'b1
    } upd_kind_e;

    typedef struct packed {
        upd_kind_e          kind;
        logic [INDEX_W-1:0] index;
        logic               taken;
        logic [TAG_W-1:0]   tag;
        logic [31:0]        target;
    } upd_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == DROP_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/bpb_update_queue_if.sv
// ---------------------------------------------------------------------------
// bpb_update_queue_if
//   Bundles the resolution input channel (execute stage -> queue) and the
//   update output channel (queue -> BPB line array).
//   Modports:
//     slave  : the update queue (consumes res_*, upd_ready; drives res_ready, upd_*)
//     master : the surrounding logic (drives res_*, upd_ready; observes the rest)
//   Signals:
//     res_valid/res_ready          resolution handshake
//     res_hit/res_taken            prediction hit flag and actual outcome
//     res_index/res_tag/res_target line index, tag and resolved target
//     upd_ready                    line array accepts an update this cycle
//     upd_index                    selected line
//     upd_w_en/upd_sw              allocation / counter-update pulses
//     upd_taken                    outcome for the counter update
//     upd_set_valid/_tag/_addr     values written on allocation
// ---------------------------------------------------------------------------
interface bpb_update_queue_if
    import bpb_pkg::*;
#(
    parameter int TAG_WIDTH   = TAG_W,
    parameter int INDEX_WIDTH = INDEX_W
);
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_hit;
    logic                   res_taken;
    logic [INDEX_WIDTH-1:0] res_index;
    logic [TAG_WIDTH-1:0]   res_tag;
    logic [31:0]            res_target;

    logic                   upd_ready;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic                   upd_w_en;
    logic                   upd_sw;
    logic                   upd_taken;
    logic                   upd_set_valid;
    logic [TAG_WIDTH-1:0]   upd_set_tag;
    logic [31:0]            upd_set_addr;

    modport slave (
        input  res_valid, res_hit, res_taken, res_index, res_tag, res_target,
        input  upd_ready,
        output res_ready,
        output upd_index, upd_w_en, upd_sw, upd_taken,
        output upd_set_valid, upd_set_tag, upd_set_addr
    );

    modport master (
        output res_valid, res_hit, res_taken, res_index, res_tag, res_target,
        output upd_ready,
        input  res_ready,
        input  upd_index, upd_w_en, upd_sw, upd_taken,
        input  upd_set_valid, upd_set_tag, upd_set_addr
    );

endinterface

// File: rtl/bpb_upd_fifo.sv
// ---------------------------------------------------------------------------
// bpb_upd_fifo
//   Circular buffer of upd_entry_t. Pointers wrap naturally at DEPTH (power
//   of two); full/empty are derived from the occupancy counter.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     push, wdata  store wdata at the tail (ignored when full)
//     pop          retire the head entry (ignored when empty)
//     rdata        head entry (contents undefined when empty)
//     count        occupied entries, 0..DEPTH
//     full, empty  occupancy flags
// ---------------------------------------------------------------------------
module bpb_upd_fifo
    import bpb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  upd_entry_t              wdata,
    input  logic                    pop,
    output upd_entry_t              rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    upd_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only read
    // while count marks it occupied, so clearing pointers and count suffices.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bpb_update_queue.sv
// ---------------------------------------------------------------------------
// bpb_update_queue
//   Buffers branch resolutions from execute and drains them one per cycle into
//   the BPB line array as allocations (upd_w_en) or counter updates (upd_sw).
//   Hits become counter updates, taken misses become allocations, not-taken
//   misses are acknowledged and discarded. Resolutions arriving while the
//   queue is full are lost and counted in drop_cnt (saturating).
//
//   Ports:
//     clk, reset  clock, synchronous active-high reset
//     bus         bpb_update_queue_if.slave (res_* in, upd_* out)
//     count       occupied entries
//     drop_cnt    resolutions lost to a full queue, saturates at 255
//
//   Build option:
//     BPB_UPDQ_BYPASS_EN  when defined, a resolution accepted into an empty
//                         queue while upd_ready=1 goes straight to upd_* in
//                         the same cycle and is not stored. When undefined
//                         there is no combinational path from res_* to upd_*.
// ---------------------------------------------------------------------------
module bpb_update_queue
    import bpb_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_WIDTH   = TAG_W,
    parameter int INDEX_WIDTH = INDEX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    bpb_update_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_cnt
);
    upd_entry_t res_entry;
    upd_entry_t head_entry;
    upd_entry_t sel_entry;
    logic       full;
    logic       empty;
    logic       has_upd;
    logic       accept;
    logic       drop;
    logic       bypass;
    logic       push;
    logic       pop;
    logic       head_valid;

    // Resolution classification: a hit updates the counter, a taken miss
    // allocates, a not-taken miss carries nothing worth storing.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        res_entry        = '0;
        res_entry.kind   = bus.res_hit ? UPD_SW : UPD_ALLOC;
        res_entry.index  = INDEX_W'(bus.res_index);
        res_entry.taken  = bus.res_taken;
        res_entry.tag    = TAG_W'(bus.res_tag);
        res_entry.target = bus.res_target;
    end

    assign has_upd = bus.res_hit | bus.res_taken;

    // res_ready comes from registered occupancy only, so a full queue refuses
    // input even when the head retires in the same cycle.
    assign bus.res_ready = ~full;

    assign accept = ~reset & bus.res_valid & ~full & has_upd;
    assign drop   = ~reset & bus.res_valid &  full & has_upd;

`ifdef BPB_UPDQ_BYPASS_EN
    assign bypass = accept & empty & bus.upd_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~bypass;
    assign pop  = ~reset & ~empty & bus.upd_ready;

    bpb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (res_entry),
        .pop   (pop),
        .rdata (head_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The presented update is the queue head, or the incoming resolution when
    // it bypasses an empty queue. Nothing is presented during reset.
    assign head_valid = ~reset & (~empty | bypass);

    always_comb begin
        sel_entry = '0;
        if (head_valid) begin
            sel_entry = bypass ? res_entry : head_entry;
        end
    end

    always_comb begin
        bus.upd_index     = INDEX_WIDTH'(sel_entry.index);
        bus.upd_taken     = sel_entry.taken;
        bus.upd_set_tag   = TAG_WIDTH'(sel_entry.tag);
        bus.upd_set_addr  = sel_entry.target;
        bus.upd_set_valid = head_valid & (sel_entry.kind == UPD_ALLOC);
        bus.upd_w_en      = head_valid & bus.upd_ready & (sel_entry.kind == UPD_ALLOC);
        bus.upd_sw        = head_valid & bus.upd_ready & (sel_entry.kind == UPD_SW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

endmodule

// File: tb/tb_bpb_update_queue.sv
// ---------------------------------------------------------------------------
// tb_bpb_update_queue
//   Self-checking bench for bpb_update_queue (DEPTH=4). Expected updates are
//   pushed to a scoreboard when a resolution is driven and popped by a
//   negedge monitor whenever upd_w_en or upd_sw pulses. A small occupancy
//   model tracks expected count and drop_cnt. Set BPB_UPDQ_BYPASS_EN to
//   exercise the bypass build.
// ---------------------------------------------------------------------------
module tb_bpb_update_queue;
    import bpb_pkg::*;

`ifdef BPB_UPDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [2:0] count;
    logic [7:0] drop_cnt;

    bpb_update_queue_if #(.TAG_WIDTH(TAG_W), .INDEX_WIDTH(INDEX_W)) bus ();

    bpb_update_queue #(
        .DEPTH       (DEPTH),
        .TAG_WIDTH   (TAG_W),
        .INDEX_WIDTH (INDEX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    upd_entry_t sb[$];
    int         m_cnt   = 0;
    logic [7:0] exp_drop = 8'd0;

    // Scoreboard monitor: every update pulse must match the oldest expectation.
    upd_entry_t mon_e;
    upd_kind_e  mon_kind;
    always @(negedge clk) begin
        if (!reset && (bus.upd_w_en || bus.upd_sw)) begin
            n_tests++;
            mon_kind = bus.upd_w_en ? UPD_ALLOC : UPD_SW;
            if (bus.upd_w_en && bus.upd_sw) begin
                n_fail++;
                $display("FAIL both_pulses: w_en=%b sw=%b required not both high", bus.upd_w_en, bus.upd_sw);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_update: kind=%0d index=%0d with empty scoreboard", mon_kind, bus.upd_index);
            end else begin
                mon_e = sb.pop_front();
                if (mon_kind !== mon_e.kind || bus.upd_index !== mon_e.index ||
                    bus.upd_taken !== mon_e.taken ||
                    bus.upd_set_valid !== (mon_e.kind == UPD_ALLOC) ||
                    (mon_e.kind == UPD_ALLOC &&
                     (bus.upd_set_tag !== mon_e.tag || bus.upd_set_addr !== mon_e.target))) begin
                    n_fail++;
                    $display("FAIL update_order: got kind=%0d idx=%0d tk=%b sv=%b tag=%0h addr=%h, required kind=%0d idx=%0d tk=%b tag=%0h addr=%h",
                             mon_kind, bus.upd_index, bus.upd_taken, bus.upd_set_valid, bus.upd_set_tag, bus.upd_set_addr,
                             mon_e.kind, mon_e.index, mon_e.taken, mon_e.tag, mon_e.target);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle's inputs and advance the reference model to the state
    // expected after the coming edge.
    task automatic drive(input logic v, input logic hit, input logic taken,
                         input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [31:0] tgt, input logic rdy);
        upd_entry_t e;
        logic       ent, full_m, pop_m, byp_m;
        bus.res_valid  = v;
        bus.res_hit    = hit;
        bus.res_taken  = taken;
        bus.res_index  = idx;
        bus.res_tag    = tag;
        bus.res_target = tgt;
        bus.upd_ready  = rdy;
        full_m = (m_cnt == DEPTH);
        ent    = v && (hit || taken);
        pop_m  = (m_cnt > 0) && rdy;
        byp_m  = BYP && (m_cnt == 0) && rdy && ent;
        if (ent && !full_m) begin
            e.kind   = hit ? UPD_SW : UPD_ALLOC;
            e.index  = idx;
            e.taken  = taken;
            e.tag    = tag;
            e.target = tgt;
            sb.push_back(e);
        end
        if (ent && full_m && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        m_cnt = m_cnt + ((ent && !full_m && !byp_m) ? 1 : 0) - (pop_m ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic hit, input logic taken,
                         input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [31:0] tgt, input logic rdy);
        drive(v, hit, taken, idx, tag, tgt, rdy);
        tick();
    endtask

    task automatic apply_reset();
        bus.res_valid = 1'b0;
        bus.upd_ready = 1'b0;
        reset = 1'b1;
        sb.delete();
        m_cnt    = 0;
        exp_drop = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (count != 0 && k < 20) begin
            cycle(1'b0, 1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
            k++;
        end
        n_tests++;
        if (count !== 3'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: count=%0d pending=%0d after %0d cycles, required 0 and 0", name, count, sb.size(), k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.res_valid = 1'b0; bus.res_hit = 1'b0; bus.res_taken = 1'b0;
        bus.res_index = '0; bus.res_tag = '0; bus.res_target = '0; bus.upd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.res_ready); end
        n_tests++;
        if (count !== 3'd0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_counts: count=%0d drop=%0d required 0/0", count, drop_cnt);
        end
        n_tests++;
        if ({bus.upd_w_en, bus.upd_sw, bus.upd_set_valid, bus.upd_taken} !== 4'b0 ||
            bus.upd_index !== '0 || bus.upd_set_tag !== '0 || bus.upd_set_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_upd: upd outputs not all zero (idx=%0d addr=%h)", bus.upd_index, bus.upd_set_addr);
        end
    endtask

    task automatic test_sw_hit();
        drive(1'b1, 1'b1, 1'b1, INDEX_W'(3), TAG_W'(0), 32'h0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus.upd_sw !== BYP) begin n_fail++; $display("FAIL sw_accept_cycle: upd_sw=%b required %b", bus.upd_sw, BYP); end
        tick();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
        n_tests++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL sw_count: got %0d required 0", count); end
    endtask

    task automatic test_alloc();
        cycle(1'b1, 1'b0, 1'b1, INDEX_W'(9), TAG_W'(5), 32'h0040_0020, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
        n_tests++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL alloc_count: got %0d required 0", count); end
        drive(1'b1, 1'b0, 1'b0, INDEX_W'(4), TAG_W'(6), 32'h1234_5678, 1'b1);
        n_tests++;
        if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL miss_nt_ready: got %b required 1", bus.res_ready); end
        @(negedge clk);
        n_tests++;
        if (bus.upd_w_en !== 1'b0 || bus.upd_sw !== 1'b0) begin
            n_fail++; $display("FAIL miss_nt_pulse: w_en=%b sw=%b required 0/0", bus.upd_w_en, bus.upd_sw);
        end
        tick();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
        n_tests++;
        if (count !== 3'd0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL miss_nt_count: count=%0d drop=%0d required 0/0", count, drop_cnt);
        end
    endtask

    task automatic test_fill_wrap();
        // Offset the pointers by one so the fill below wraps mid-queue.
        cycle(1'b1, 1'b0, 1'b1, INDEX_W'(2), TAG_W'(7), 32'hA000_0000, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, i[0], INDEX_W'(i + 1), TAG_W'(i), 32'h100 + i, 1'b0);
            if (i == 3) begin
                n_tests++;
                if (bus.res_ready !== 1'b0 || count !== 3'd4) begin
                    n_fail++; $display("FAIL fill_full: ready=%b count=%0d required 0/4", bus.res_ready, count);
                end
            end
        end
        n_tests++;
        if (drop_cnt !== 8'd1 || drop_cnt !== exp_drop) begin
            n_fail++; $display("FAIL fill_drop: got %0d required 1", drop_cnt);
        end
        drain("fill_wrap");
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i[1], 1'b1, INDEX_W'(10 + i), TAG_W'(20 + i), 32'h2000 + i, 1'b0);
        end
        n_tests++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL simul_fill: count=%0d required 4", count); end
        drive(1'b1, 1'b1, 1'b0, INDEX_W'(30), TAG_W'(1), 32'h0, 1'b1);
        n_tests++;
        if (bus.res_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready: got %b required 0", bus.res_ready); end
        tick();
        n_tests++;
        if (count !== 3'd3 || drop_cnt !== 8'd2 || drop_cnt !== exp_drop) begin
            n_fail++; $display("FAIL simul_after: count=%0d drop=%0d required 3/2", count, drop_cnt);
        end
        drain("full_simul");
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, INDEX_W'(i), TAG_W'(0), 32'h0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, INDEX_W'(1), TAG_W'(0), 32'h0, 1'b0);
        n_tests++;
        if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL nt_not_drop: got %0d required %0d", drop_cnt, exp_drop); end
        for (int i = 0; i < 260; i++) begin
            cycle(1'b1, 1'b1, 1'b1, INDEX_W'(i % 8), TAG_W'(0), 32'h0, 1'b0);
        end
        n_tests++;
        if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_saturate: got %0d required 255", drop_cnt); end
        drain("drop_saturate");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, INDEX_W'(5 + i), TAG_W'(3), 32'h3000, 1'b0);
        end
        n_tests++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL mid_fill: count=%0d required 3", count); end
        apply_reset();
        n_tests++;
        if (count !== 3'd0 || bus.res_ready !== 1'b1 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset_state: count=%0d ready=%b drop=%0d required 0/1/0", count, bus.res_ready, drop_cnt);
        end
        n_tests++;
        if ({bus.upd_w_en, bus.upd_sw, bus.upd_set_valid} !== 3'b0 || bus.upd_index !== '0 || bus.upd_set_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_upd: w_en=%b sw=%b sv=%b idx=%0d required zeros",
                               bus.upd_w_en, bus.upd_sw, bus.upd_set_valid, bus.upd_index);
        end
        bus.upd_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.upd_w_en !== 1'b0 || bus.upd_sw !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_stale: w_en=%b sw=%b required 0/0", bus.upd_w_en, bus.upd_sw);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 1'b0, INDEX_W'(7), TAG_W'(0), 32'h0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus.upd_sw !== BYP) begin n_fail++; $display("FAIL bypass_same: upd_sw=%b required %b", bus.upd_sw, BYP); end
        tick();
        n_tests++;
        if (count !== 3'(m_cnt)) begin n_fail++; $display("FAIL bypass_count: got %0d required %0d", count, m_cnt); end
        drive(1'b0, 1'b0, 1'b0, '0, '0, 32'h0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus.upd_sw !== !BYP || (bus.upd_sw && bus.upd_index !== INDEX_W'(7))) begin
            n_fail++; $display("FAIL bypass_next: upd_sw=%b idx=%0d required %b", bus.upd_sw, bus.upd_index, !BYP);
        end
        tick();
        n_tests++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_end: count=%0d required 0", count); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, i[0], 1'b1, INDEX_W'(i * 3), TAG_W'(i + 1), 32'h4000 + 4 * i, 1'b1);
            if (count !== 3'(m_cnt)) bad++;
        end
        n_tests++;
        if (bad != 0 || count > 3'd1) begin
            n_fail++; $display("FAIL b2b_stream: %0d count deviations, final count=%0d required <=1", bad, count);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            logic v, h, t, r;
            v = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            cycle(v, h, t, INDEX_W'($urandom_range(0, BPB_ENTRIES - 1)), TAG_W'($urandom),
                  32'($urandom), r);
            if (count !== 3'(m_cnt)) bad++;
        end
        n_tests++;
        if (bad != 0 || drop_cnt !== exp_drop) begin
            n_fail++; $display("FAIL b2b_random: %0d count deviations, drop=%0d required %0d", bad, drop_cnt, exp_drop);
        end
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_sw_hit();
        test_alloc();
        test_fill_wrap();
        test_full_simul();
        test_drop_saturate();
        test_reset_mid();
        test_bypass();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bpb_update_queue.md
# bpb_update_queue

Buffers branch resolutions from the execute stage and drains them, one per cycle, into the branch prediction buffer line array as allocation writes or saturating-counter updates. Sits directly upstream of the BPB lines: it generates their `w_en`, `sw`, `taken`, `set_valid`, `set_tag` and `set_addr` inputs and the line index that selects them. Decouples execute-stage resolution bursts from line-array update bandwidth.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `TAG_WIDTH`, `` `BPB_T ``, tag width, from bpb.vh
- `INDEX_WIDTH`, `$clog2(`BPB_E)`, line index width
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `res_valid`  in  1  execute stage presents a resolved branch
- `res_ready`  out  1  queue can accept; equals ~full
- `res_hit`  in  1  branch was predicted from a valid BPB line
- `res_taken`  in  1  actual branch outcome
- `res_index`  in  INDEX_WIDTH  line index of the branch PC
- `res_tag`  in  TAG_WIDTH  tag of the branch PC
- `res_target`  in  32  resolved target address
- `upd_ready`  in  1  line array accepts an update this cycle
- `upd_index`  out  INDEX_WIDTH  line selected by the current update
- `upd_w_en`  out  1  allocation pulse to the selected line
- `upd_sw`  out  1  counter-update pulse to the selected line
- `upd_taken`  out  1  outcome for the counter update
- `upd_set_valid`  out  1  valid bit written on allocation
- `upd_set_tag`  out  TAG_WIDTH  tag written on allocation
- `upd_set_addr`  out  32  target written on allocation
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `drop_cnt`  out  8  saturating count of resolutions lost to a full queue

## Operation
- Accept when `res_valid & res_ready`. Classification at accept:
  - `res_hit=1` → kind SW (counter update, carries `res_taken`)
  - `res_hit=0, res_taken=1` → kind ALLOC (carries tag, target)
  - `res_hit=0, res_taken=0` → handshake completes, nothing enqueued, count unchanged
- Head entry drives `upd_index`, `upd_taken`, `upd_set_*` whenever the queue is non-empty; otherwise all zero.
- `upd_w_en` = non-empty & upd_ready & kind ALLOC; `upd_sw` = non-empty & upd_ready & kind SW; never both high. `upd_set_valid` = 1 for ALLOC heads, 0 otherwise.
- Dequeue on every cycle where `upd_w_en | upd_sw`.
- Strict FIFO order; no reordering or merging of updates to the same index.
- Full: `res_ready=0`; `res_valid` while full drops the resolution and increments `drop_cnt` (saturates at 255); non-hit not-taken resolutions never count as drops.
- Simultaneous enqueue and dequeue: both occur, count unchanged. Enqueue into a full queue is refused even if a dequeue happens the same cycle.
- Read/write pointers of $clog2(DEPTH) bits wrap naturally; full/empty from `count`.

## Timing
- Reset (synchronous): pointers, count, `drop_cnt` to 0; all `upd_*` outputs 0; `res_ready`=1. Reset mid-operation discards every queued entry the same edge.
- Latency without bypass: accepted at edge N, visible on `upd_*` in cycle N+1, retired at first edge with `upd_ready`=1.
- Throughput: one accept and one retire per cycle.
- `res_ready` depends only on registered state (no combinational path from `upd_ready`).

## Configuration
- `BPB_UPDQ_BYPASS_EN` defined: when the queue is empty and `upd_ready`=1, an accepted ALLOC/SW resolution is driven onto `upd_*` combinationally in the same cycle and not stored (0-cycle latency); if `upd_ready`=0 it is stored normally.
- Undefined: every resolution is stored; minimum latency 1 cycle; no combinational path from `res_*` to `upd_*`.

## Structure
- Package `bpb_pkg`: `upd_kind_e` (UPD_SW, UPD_ALLOC), `upd_entry_t` struct (kind, index, taken, tag, target), `DROP_CNT_MAX` constant.
- One sub-module `bpb_upd_fifo`: parameterised storage of `upd_entry_t`, pointers, count, full/empty; classification, output gating, bypass and drop counter stay in the top.

## Test plan
- Reset, then single hit/taken at index 3 with `upd_ready`=1 → `upd_sw`=1, `upd_taken`=1, `upd_index`=3 one cycle later; count returns to 0.
- Miss/taken, tag 0x5, target 0x0040_0020 → one-cycle `upd_w_en` with `upd_set_valid`=1, tag 0x5, addr 0x0040_0020; miss/not-taken → no pulse, count stays 0.
- `upd_ready`=0, push 5 resolutions at DEPTH=4 → `res_ready`=0 after 4th, `drop_cnt`=1; raise `upd_ready` → 4 pulses in FIFO order, pointer wrap observed.
- Full queue with simultaneous dequeue and `res_valid` → input refused, `drop_cnt` increments, count goes 4→3.
- Assert `reset` with 3 entries queued → next cycle count=0, `upd_*`=0, `res_ready`=1.
- With `BPB_UPDQ_BYPASS_EN`, empty queue, `upd_ready`=1, hit resolution → `upd_sw` same cycle, count stays 0; without macro → pulse one cycle later.
